// File: rtl/chunked_adder.sv
// chunked_adder: WIDTH-bit adder built from one 2-bit carry slice, walking the
// operands LSB chunk first with a registered carry between chunks.

module chunked_adder_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {2'b00, cin};
endmodule

module chunked_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_lhs,
    input  logic [WIDTH-1:0] io_in_rhs,
    input  logic             io_in_cin,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_sum,
    output logic             io_out_cout
);
    localparam int NUM   = WIDTH / 2;
    localparam int CNT_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] lhs_sh, rhs_sh, sum_q, sum_next;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       slice_out;
    logic             slice_cout;
    logic             last_chunk;

    chunked_adder_slice u_slice (
        .a    (lhs_sh[1:0]),
        .b    (rhs_sh[1:0]),
        .cin  (carry_q),
        .sum  (slice_out),
        .cout (slice_cout)
    );

    // New chunks enter at the top so the LSB chunk ends up at bit 0 after NUM shifts.
    generate
        if (WIDTH == 2) begin : g_sum_narrow
            assign sum_next = slice_out;
        end else begin : g_sum_wide
            assign sum_next = {slice_out, sum_q[WIDTH-1:2]};
        end
    endgenerate

    assign last_chunk = (cnt == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (io_in_valid)  next_state = BUSY;
            BUSY:    if (last_chunk)   next_state = DONE;
            DONE:    if (io_out_ready) next_state = IDLE;
            default:                   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lhs_sh  <= '0;
            rhs_sh  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io_in_valid) begin
                        lhs_sh  <= io_in_lhs;
                        rhs_sh  <= io_in_rhs;
                        carry_q <= io_in_cin;
                        cnt     <= '0;
                        sum_q   <= '0;
                    end
                end
                BUSY: begin
                    lhs_sh  <= lhs_sh >> 2;
                    rhs_sh  <= rhs_sh >> 2;
                    sum_q   <= sum_next;
                    carry_q <= slice_cout;
                    cnt     <= cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign io_in_ready  = (state == IDLE);
    assign io_out_valid = (state == DONE);
    assign io_out_sum   = sum_q;
    assign io_out_cout  = carry_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed and random checks of chunked_adder at WIDTH=8, plus random
// checks of WIDTH=2 and WIDTH=16 instances against a golden wide sum.

module tb_chunked_adder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic       in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
    logic [7:0] in_lhs, in_rhs, out_sum;

    logic       in_valid_w2, in_ready_w2, in_cin_w2, out_valid_w2, out_ready_w2, out_cout_w2;
    logic [1:0] in_lhs_w2, in_rhs_w2, out_sum_w2;

    logic        in_valid_w16, in_ready_w16, in_cin_w16, out_valid_w16, out_ready_w16, out_cout_w16;
    logic [15:0] in_lhs_w16, in_rhs_w16, out_sum_w16;

    chunked_adder #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready),
        .io_in_lhs(in_lhs), .io_in_rhs(in_rhs), .io_in_cin(in_cin),
        .io_out_valid(out_valid), .io_out_ready(out_ready),
        .io_out_sum(out_sum), .io_out_cout(out_cout)
    );

    chunked_adder #(.WIDTH(2)) dut_w2 (
        .clk(clk), .reset(reset),
        .io_in_valid(in_valid_w2), .io_in_ready(in_ready_w2),
        .io_in_lhs(in_lhs_w2), .io_in_rhs(in_rhs_w2), .io_in_cin(in_cin_w2),
        .io_out_valid(out_valid_w2), .io_out_ready(out_ready_w2),
        .io_out_sum(out_sum_w2), .io_out_cout(out_cout_w2)
    );

    chunked_adder #(.WIDTH(16)) dut_w16 (
        .clk(clk), .reset(reset),
        .io_in_valid(in_valid_w16), .io_in_ready(in_ready_w16),
        .io_in_lhs(in_lhs_w16), .io_in_rhs(in_rhs_w16), .io_in_cin(in_cin_w16),
        .io_out_valid(out_valid_w16), .io_out_ready(out_ready_w16),
        .io_out_sum(out_sum_w16), .io_out_cout(out_cout_w16)
    );

    // Presents one operand pair to the WIDTH=8 instance and waits for the result.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input bit scramble, output int lat, output bit timed_out);
        @(negedge clk);
        in_valid = 1'b1; in_lhs = a; in_rhs = b; in_cin = c;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (scramble) begin
                in_lhs = 8'($urandom);
                in_rhs = 8'($urandom);
                in_cin = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        timed_out = !out_valid;
    endtask

    task automatic release_op8();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        n_compared++;
        if ({in_ready, out_valid, out_cout, out_sum} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_mismatched++;
            $display("[TB] FAIL reset_state: got %b, expected %b",
                     {in_ready, out_valid, out_cout, out_sum}, {1'b1, 1'b0, 1'b0, 8'h00});
        end
        reset = 1'b0;
        @(negedge clk);
        n_compared++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_mismatched++;
            $display("[TB] FAIL idle_after_reset: got %b, expected 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_basic();
        int lat;
        bit to;
        run_op8(8'h12, 8'h34, 1'b0, 1'b0, lat, to);
        n_compared++;
        if (lat !== 4 || to !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_latency: got %0d (timeout %0d), expected 4", lat, to);
        end
        n_compared++;
        if ({out_cout, out_sum} !== 9'h046) begin
            n_mismatched++;
            $display("[TB] FAIL basic_sum: got %h, expected 046", {out_cout, out_sum});
        end
        n_compared++;
        if (in_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_ready_in_done: got %b, expected 0", in_ready);
        end
        release_op8();
        n_compared++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_mismatched++;
            $display("[TB] FAIL basic_return_idle: got %b, expected 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_ripple();
        int lat;
        bit to;
        run_op8(8'hFF, 8'h01, 1'b0, 1'b0, lat, to);
        n_compared++;
        if ({to, out_cout, out_sum} !== {1'b0, 9'h100}) begin
            n_mismatched++;
            $display("[TB] FAIL ripple_ff_01: got %h, expected 100", {to, out_cout, out_sum});
        end
        release_op8();
        run_op8(8'hA5, 8'h5A, 1'b1, 1'b0, lat, to);
        n_compared++;
        if ({to, out_cout, out_sum} !== {1'b0, 9'h100}) begin
            n_mismatched++;
            $display("[TB] FAIL ripple_a5_5a_c1: got %h, expected 100", {to, out_cout, out_sum});
        end
        release_op8();
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        run_op8(8'h80, 8'h80, 1'b1, 1'b0, lat, to);
        for (int i = 0; i < 7; i++) begin
            n_compared++;
            if ({to, out_valid, in_ready, out_cout, out_sum} !== {4'b0101, 8'h01}) begin
                n_mismatched++;
                $display("[TB] FAIL backpressure_hold[%0d]: got %b, expected %b", i,
                         {to, out_valid, in_ready, out_cout, out_sum}, {4'b0101, 8'h01});
            end
            if (i < 6) @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_compared++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_mismatched++;
            $display("[TB] FAIL backpressure_release: got %b, expected 10", {in_ready, out_valid});
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_isolation();
        int lat;
        bit to;
        run_op8(8'h3C, 8'h0F, 1'b1, 1'b1, lat, to);
        n_compared++;
        if ({to, out_cout, out_sum} !== {1'b0, 9'h04C}) begin
            n_mismatched++;
            $display("[TB] FAIL input_isolation: got %h, expected 04c", {to, out_cout, out_sum});
        end
        release_op8();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit to;
        bit saw_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_lhs = 8'hFF; in_rhs = 8'hFF; in_cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_compared++;
        if ({in_ready, out_valid, out_cout, out_sum} !== {3'b100, 8'h00}) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_busy: got %b, expected %b",
                     {in_ready, out_valid, out_cout, out_sum}, {3'b100, 8'h00});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        n_compared++;
        if (saw_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_no_valid: got %b, expected 0", saw_valid);
        end
        run_op8(8'h01, 8'h01, 1'b0, 1'b0, lat, to);
        n_compared++;
        if ({to, out_cout, out_sum} !== {1'b0, 9'h002}) begin
            n_mismatched++;
            $display("[TB] FAIL reset_then_add: got %h, expected 002", {to, out_cout, out_sum});
        end
        release_op8();
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int waited = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_lhs = 8'h12; in_rhs = 8'h34; in_cin = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (in_ready) acc.push_back(cyc);
            if (out_valid) begin
                n_compared++;
                if ({out_cout, out_sum} !== 9'h046) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_sum@%0d: got %h, expected 046", cyc, {out_cout, out_sum});
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_compared++;
        if (acc.size() < 3) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_accept_count: got %0d, expected >= 3", acc.size());
        end else begin
            for (int k = 1; k < acc.size(); k++) begin
                n_compared++;
                if (acc[k] - acc[k-1] !== 6) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_interval[%0d]: got %0d, expected 6", k, acc[k] - acc[k-1]);
                end
            end
        end
        while (!(in_ready && !out_valid) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random_w8();
        int lat;
        bit to;
        logic [7:0] a, b;
        logic c;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            run_op8(a, b, c, 1'b0, lat, to);
            n_compared++;
            if ({to, out_cout, out_sum} !== {1'b0, {1'b0, a} + {1'b0, b} + {8'h00, c}}) begin
                n_mismatched++;
                $display("[TB] FAIL random_w8 %h+%h+%b: got %h, expected %h", a, b, c,
                         {to, out_cout, out_sum}, {1'b0, {1'b0, a} + {1'b0, b} + {8'h00, c}});
            end
            release_op8();
        end
    endtask

    task automatic test_random_w2();
        int lat;
        logic [1:0] a, b;
        logic c;
        for (int i = 0; i < 1000; i++) begin
            a = 2'($urandom); b = 2'($urandom); c = 1'($urandom);
            @(negedge clk);
            in_valid_w2 = 1'b1; in_lhs_w2 = a; in_rhs_w2 = b; in_cin_w2 = c;
            @(posedge clk);
            @(negedge clk);
            in_valid_w2 = 1'b0;
            lat = 0;
            while (!out_valid_w2 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            n_compared++;
            if ({!out_valid_w2, lat == 1, out_cout_w2, out_sum_w2} !==
                {2'b01, {1'b0, a} + {1'b0, b} + {2'b00, c}}) begin
                n_mismatched++;
                $display("[TB] FAIL random_w2 %h+%h+%b: got %h (lat %0d), expected %h", a, b, c,
                         {out_cout_w2, out_sum_w2}, lat, {1'b0, a} + {1'b0, b} + {2'b00, c});
            end
            out_ready_w2 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready_w2 = 1'b0;
        end
    endtask

    task automatic test_random_w16();
        int lat;
        logic [15:0] a, b;
        logic c;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
            @(negedge clk);
            in_valid_w16 = 1'b1; in_lhs_w16 = a; in_rhs_w16 = b; in_cin_w16 = c;
            @(posedge clk);
            @(negedge clk);
            in_valid_w16 = 1'b0;
            lat = 0;
            while (!out_valid_w16 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            n_compared++;
            if ({!out_valid_w16, lat == 8, out_cout_w16, out_sum_w16} !==
                {2'b01, {1'b0, a} + {1'b0, b} + {16'h0000, c}}) begin
                n_mismatched++;
                $display("[TB] FAIL random_w16 %h+%h+%b: got %h (lat %0d), expected %h", a, b, c,
                         {out_cout_w16, out_sum_w16}, lat, {1'b0, a} + {1'b0, b} + {16'h0000, c});
            end
            out_ready_w16 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready_w16 = 1'b0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_valid = 1'b0; in_lhs = '0; in_rhs = '0; in_cin = 1'b0; out_ready = 1'b0;
        in_valid_w2 = 1'b0; in_lhs_w2 = '0; in_rhs_w2 = '0; in_cin_w2 = 1'b0; out_ready_w2 = 1'b0;
        in_valid_w16 = 1'b0; in_lhs_w16 = '0; in_rhs_w16 = '0; in_cin_w16 = 1'b0; out_ready_w16 = 1'b0;
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
        test_isolation();
        test_reset_mid();
        test_back_to_back();
        test_random_w8();
        test_random_w2();
        test_random_w16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
